// File: rtl/phase_acc_pkg.sv
// Shared types and constants for the phase_acc NCO phase accumulator.
// Galois LFSR constants are only used when PHASE_DITHER_EN is defined.
package phase_acc_pkg;

   localparam int unsigned OUT_W     = 16;
   localparam logic [15:0] LFSR_SEED = 16'hACE1;
   // Right-shift Galois form of x^16 + x^14 + x^13 + x^11 + 1.
   localparam logic [15:0] LFSR_TAPS = 16'hB400;

   typedef enum logic {
      PEND_EMPTY,
      PEND_FULL
   } pend_t;

   function automatic logic [15:0] lfsr_next(input logic [15:0] s);
      return (s >> 1) ^ (s[0] ? LFSR_TAPS : 16'h0000);
   endfunction

endpackage

// File: rtl/phase_acc_lfsr.sv
// 16-bit Galois LFSR with advance enable; resets to LFSR_SEED.
// Used by phase_acc only when PHASE_DITHER_EN is defined.
module phase_acc_lfsr
   import phase_acc_pkg::*;
(
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_adv,
   output logic [15:0] o_lfsr
);

   logic [15:0] lfsr_q, lfsr_d;

   always_comb begin
      lfsr_d = lfsr_q;
      if (i_adv) begin
         lfsr_d = lfsr_next(lfsr_q);
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         lfsr_q <= LFSR_SEED;
      end else begin
         lfsr_q <= lfsr_d;
      end
   end

   assign o_lfsr = lfsr_q;

endmodule

// File: rtl/phase_acc.sv
// Phase accumulator producing a 16-bit sawtooth phase word, with a one-deep FCW
// pending slot. Defining PHASE_DITHER_EN adds LFSR dither to o_saw only.
module phase_acc
   import phase_acc_pkg::*;
#(
   parameter int unsigned      ACC_W    = 32,
   parameter logic [ACC_W-1:0] INIT_FCW = '0
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_en,
   input  logic             i_tick,
   input  logic             i_sync,
   input  logic [ACC_W-1:0] i_fcw,
   input  logic             i_fcw_valid,
   output logic             o_fcw_ready,
   output logic [15:0]      o_saw,
   output logic             o_valid,
   output logic             o_wrap
);

   logic             step;
   logic [ACC_W-1:0] acc_q, acc_d;
   logic [ACC_W-1:0] fcw_act_q, fcw_act_d;
   logic [ACC_W-1:0] pend_word_q, pend_word_d;
   pend_t            pend_q, pend_d;
   logic [OUT_W-1:0] saw_q, saw_d;
   logic             valid_q, valid_d;
   logic             wrap_q, wrap_d;
   logic [ACC_W-1:0] fcw_eff;
   logic [ACC_W:0]   sum;
   logic [OUT_W-1:0] saw_new;

   assign step = i_tick & i_en;

   // A step consumes a waiting word directly, so the new FCW takes effect on this tick.
   assign fcw_eff = (step && (pend_q == PEND_FULL)) ? pend_word_q : fcw_act_q;
   assign sum     = {1'b0, acc_q} + {1'b0, fcw_eff};

`ifdef PHASE_DITHER_EN
   logic [15:0]      lfsr;
   logic [ACC_W-1:0] dith_sum;

   phase_acc_lfsr u_lfsr (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_adv   (step),
      .o_lfsr  (lfsr)
   );

   assign dith_sum = sum[ACC_W-1:0] + {{16{1'b0}}, lfsr[ACC_W-17:0]};
   assign saw_new  = dith_sum[ACC_W-1 -: OUT_W];
`else
   assign saw_new  = sum[ACC_W-1 -: OUT_W];
`endif

   always_comb begin
      pend_d      = pend_q;
      pend_word_d = pend_word_q;
      fcw_act_d   = fcw_act_q;
      unique case (pend_q)
         PEND_EMPTY: begin
            if (i_fcw_valid) begin
               pend_word_d = i_fcw;
               pend_d      = PEND_FULL;
            end
         end
         PEND_FULL: begin
            // While held, the word is retired immediately so the slot frees up.
            if (step || !i_en) begin
               fcw_act_d = pend_word_q;
               pend_d    = PEND_EMPTY;
            end
         end
      endcase
   end

   always_comb begin
      acc_d   = acc_q;
      saw_d   = saw_q;
      valid_d = 1'b0;
      wrap_d  = 1'b0;
      if (i_sync) begin
         acc_d = '0;
         if (step) begin
            saw_d   = '0;
            valid_d = 1'b1;
         end
      end else if (step) begin
         acc_d   = sum[ACC_W-1:0];
         wrap_d  = sum[ACC_W];
         saw_d   = saw_new;
         valid_d = 1'b1;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         acc_q       <= '0;
         fcw_act_q   <= INIT_FCW;
         pend_word_q <= '0;
         pend_q      <= PEND_EMPTY;
         saw_q       <= '0;
         valid_q     <= 1'b0;
         wrap_q      <= 1'b0;
      end else begin
         acc_q       <= acc_d;
         fcw_act_q   <= fcw_act_d;
         pend_word_q <= pend_word_d;
         pend_q      <= pend_d;
         saw_q       <= saw_d;
         valid_q     <= valid_d;
         wrap_q      <= wrap_d;
      end
   end

   assign o_fcw_ready = (pend_q == PEND_EMPTY);
   assign o_saw       = saw_q;
   assign o_valid     = valid_q;
   assign o_wrap      = wrap_q;

endmodule

// File: tb/tb_phase_acc.sv
// Scoreboard bench for phase_acc: directed stimulus pushes expected {saw, wrap}
// entries, a forked monitor pops and compares on every o_valid pulse.
module tb_phase_acc;

   localparam int unsigned ACC_W = 32;

   logic             i_clk = 1'b0;
   logic             i_rst_n;
   logic             i_en;
   logic             i_tick;
   logic             i_sync;
   logic [ACC_W-1:0] i_fcw;
   logic             i_fcw_valid;
   logic             o_fcw_ready;
   logic [15:0]      o_saw;
   logic             o_valid;
   logic             o_wrap;

   int pass_cnt  = 0;
   int total_cnt = 0;
   logic [16:0] exp_q[$];

   phase_acc #(
      .ACC_W    (ACC_W),
      .INIT_FCW ('0)
   ) dut (
      .i_clk       (i_clk),
      .i_rst_n     (i_rst_n),
      .i_en        (i_en),
      .i_tick      (i_tick),
      .i_sync      (i_sync),
      .i_fcw       (i_fcw),
      .i_fcw_valid (i_fcw_valid),
      .o_fcw_ready (o_fcw_ready),
      .o_saw       (o_saw),
      .o_valid     (o_valid),
      .o_wrap      (o_wrap)
   );

   always #5 i_clk = ~i_clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act === exp) begin
         pass_cnt++;
      end else begin
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic expect_out(input logic [15:0] saw, input logic wrap);
      exp_q.push_back({saw, wrap});
   endtask

   task automatic monitor();
      logic [16:0] e;
      forever begin
         @(negedge i_clk);
         if (i_rst_n && o_valid) begin
            if (exp_q.size() == 0) begin
               check("unexpected_valid", {31'b0, o_valid}, 32'd0);
            end else begin
               e = exp_q.pop_front();
               check("saw", {16'b0, o_saw}, {16'b0, e[16:1]});
               check("wrap", {31'b0, o_wrap}, {31'b0, e[0]});
            end
         end else if (i_rst_n) begin
            check("wrap_without_valid", {31'b0, o_wrap}, 32'd0);
         end
      end
   endtask

   // Applies inputs, then returns 1 time unit after the next rising edge.
   task automatic drive(input logic en, input logic tick, input logic sync, input logic fv,
                        input logic [ACC_W-1:0] fcw);
      i_en        = en;
      i_tick      = tick;
      i_sync      = sync;
      i_fcw_valid = fv;
      i_fcw       = fcw;
      @(posedge i_clk);
      #1;
   endtask

`ifdef PHASE_DITHER_EN
   function automatic logic [15:0] lfsr_model(input logic [15:0] s);
      logic [15:0] n;
      n = {1'b0, s[15:1]};
      if (s[0]) n = n ^ 16'b1011_0100_0000_0000;
      return n;
   endfunction
`endif

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      i_rst_n     = 1'b0;
      i_en        = 1'b0;
      i_tick      = 1'b0;
      i_sync      = 1'b0;
      i_fcw_valid = 1'b0;
      i_fcw       = '0;
      fork
         monitor();
      join_none
      repeat (2) @(posedge i_clk);
      @(negedge i_clk);
      i_rst_n = 1'b1;
      @(negedge i_clk);
      check("rst_saw", {16'b0, o_saw}, 32'd0);
      check("rst_valid", {31'b0, o_valid}, 32'd0);
      check("rst_wrap", {31'b0, o_wrap}, 32'd0);
      check("rst_ready", {31'b0, o_fcw_ready}, 32'd1);

`ifdef PHASE_DITHER_EN
      begin
         logic [15:0] l;
         l = 16'hACE1;
         drive(1, 0, 0, 1, 32'h0001_8000);
         expect_out(16'h0002, 1'b0);
         drive(1, 1, 0, 0, 0);
         drive(1, 0, 0, 1, 32'h0000_0000);
         for (int k = 0; k < 8; k++) begin
            l = lfsr_model(l);
            expect_out(l[15] ? 16'h0002 : 16'h0001, 1'b0);
            drive(1, 1, 0, 0, 0);
         end
      end
`else
      // Unit FCW, tick every cycle.
      drive(1, 0, 0, 1, 32'h0001_0000);
      check("ready_after_write", {31'b0, o_fcw_ready}, 32'd0);
      for (int i = 1; i <= 5; i++) begin
         expect_out(i[15:0], 1'b0);
         drive(1, 1, 0, 0, 0);
      end

      // Sync without a step clears acc but leaves o_saw alone.
      drive(1, 0, 1, 0, 0);
      check("sync_no_step_valid", {31'b0, o_valid}, 32'd0);
      check("sync_no_step_saw", {16'b0, o_saw}, 32'h0005);

      // Quarter-turn FCW, tick every 4 cycles; wrap on the fourth.
      drive(1, 0, 0, 1, 32'h4000_0000);
      expect_out(16'h4000, 1'b0);
      expect_out(16'h8000, 1'b0);
      expect_out(16'hC000, 1'b0);
      expect_out(16'h0000, 1'b1);
      for (int i = 0; i < 4; i++) begin
         drive(1, 1, 0, 0, 0);
         repeat (3) drive(1, 0, 0, 0, 0);
      end

      // Back-to-back writes: second is held until the slot frees after a tick.
      drive(1, 0, 0, 1, 32'h0002_0000);
      check("b2b_ready_1", {31'b0, o_fcw_ready}, 32'd0);
      drive(1, 0, 0, 1, 32'h0003_0000);
      check("b2b_ready_2", {31'b0, o_fcw_ready}, 32'd0);
      expect_out(16'h0002, 1'b0);
      drive(1, 1, 0, 1, 32'h0003_0000);
      check("b2b_ready_after_tick", {31'b0, o_fcw_ready}, 32'd1);
      drive(1, 0, 0, 1, 32'h0003_0000);
      check("b2b_second_accepted", {31'b0, o_fcw_ready}, 32'd0);
      expect_out(16'h0005, 1'b0);
      drive(1, 1, 0, 0, 0);

      // Sync with a tick from acc=8000_0000; pending transfer still happens.
      drive(1, 0, 1, 1, 32'h8000_0000);
      expect_out(16'h8000, 1'b0);
      drive(1, 1, 0, 0, 0);
      drive(1, 0, 0, 1, 32'h1234_5678);
      expect_out(16'h0000, 1'b0);
      drive(1, 1, 1, 0, 0);
      check("sync_tick_ready", {31'b0, o_fcw_ready}, 32'd1);
      expect_out(16'h1234, 1'b0);
      drive(1, 1, 0, 0, 0);
      expect_out(16'h2468, 1'b0);
      drive(1, 1, 0, 0, 0);

      // Hold with ticks continuing; the pending word retires in one cycle.
      drive(1, 0, 0, 1, 32'h0001_0000);
      drive(0, 1, 0, 0, 0);
      check("hold_ready", {31'b0, o_fcw_ready}, 32'd1);
      check("hold_valid", {31'b0, o_valid}, 32'd0);
      drive(0, 1, 0, 0, 0);
      check("hold_saw", {16'b0, o_saw}, 32'h2468);
      expect_out(16'h2469, 1'b0);
      drive(1, 1, 0, 0, 0);

      // Asynchronous reset mid-run, with a pending word and o_valid high.
      drive(1, 1, 0, 1, 32'h0005_0000);
      check("pre_rst_valid", {31'b0, o_valid}, 32'd1);
      check("pre_rst_saw", {16'b0, o_saw}, 32'h246A);
      check("pre_rst_ready", {31'b0, o_fcw_ready}, 32'd0);
      #1 i_rst_n = 1'b0;
      #1;
      check("async_rst_saw", {16'b0, o_saw}, 32'd0);
      check("async_rst_valid", {31'b0, o_valid}, 32'd0);
      check("async_rst_wrap", {31'b0, o_wrap}, 32'd0);
      check("async_rst_ready", {31'b0, o_fcw_ready}, 32'd1);
      #1 i_rst_n = 1'b1;

      // INIT_FCW of zero holds phase but still pulses o_valid.
      expect_out(16'h0000, 1'b0);
      expect_out(16'h0000, 1'b0);
      drive(1, 1, 0, 0, 0);
      drive(1, 1, 0, 0, 0);
`endif

      repeat (3) drive(1, 0, 0, 0, 0);
      check("queue_drained", exp_q.size(), 32'd0);
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
